// File: rtl/wb_indirect_buffer_port.sv
// ---------------------------------------------------------------------------
// wb_indirect_buffer_port
//
// Wishbone classic slave that gives the host indirect access to
// G_NUM_CHANNELS on-chip sample buffers. Access goes through one pointer
// register (channel + word pointer) and one auto-incrementing data register.
// Sticky status flags record a pointer wrap and an access to a channel that
// does not exist.
//
// Register map (wb_adr_i):
//   0 PTR    R/W  write: ptr = dat[G_DEPTH_LOG2-1:0], chan = dat[19:16],
//                 clears wrapped/err. read: {12'h0, chan, zeros, ptr}
//   1 DATA   R/W  mem[chan][ptr] access, then ptr++ (mod depth)
//   2 STATUS RO   bit0 wrapped, bit1 err, [15:8] channels, [20:16] depth log2
//   3 -      reads 0, writes acked and ignored
//
// Handshake: a request is wb_cyc_i & wb_stb_i sampled in IDLE. wb_ack_o is
// a single-cycle pulse; stb is ignored while the ack is high. Dropping
// wb_cyc_i while a DATA read waits for the RAM aborts it with no ack and no
// side effects. Register side effects land on the edge that raises the ack.
//
// Ports:
//   clk_sys_i       system clock
//   rst_i           synchronous active-high reset (RAM contents kept)
//   wb_adr_i[1:0]   word address
//   wb_dat_i[31:0]  write data
//   wb_dat_o[31:0]  read data, held between accesses, updated on read acks
//   wb_cyc_i        bus cycle
//   wb_stb_i        strobe
//   wb_we_i         write enable
//   wb_ack_o        acknowledge
//   wrap_o          mirror of STATUS.wrapped
//   err_o           mirror of STATUS.err
//
// Optional feature macro: WB_INDIRECT_BUFFER_PREFETCH_EN
//   Defined:   a prefetch register keeps mem[chan][ptr] ready so a DATA read
//              can ack at latency 1; while a refill is in progress the read
//              waits for it (latency at most 3).
//   Undefined: DATA reads always ack at latency 2.
// ---------------------------------------------------------------------------
module wb_indirect_buffer_port #(
    parameter int G_DATA_WIDTH   = 32,
    parameter int G_DEPTH_LOG2   = 8,
    parameter int G_NUM_CHANNELS = 2
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        wrap_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << G_DEPTH_LOG2;
    localparam int CHW   = (G_NUM_CHANNELS > 1) ? $clog2(G_NUM_CHANNELS) : 1;

    localparam logic [4:0] NUM_CH_5 = 5'(G_NUM_CHANNELS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;

    localparam logic [1:0] A_PTR    = 2'd0;
    localparam logic [1:0] A_DATA   = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;

    logic [1:0]              r_state;
    logic [G_DEPTH_LOG2-1:0] r_ptr;
    logic [3:0]              r_chan;
    logic                    r_wrapped;
    logic                    r_err;
    logic [31:0]             r_dat_o;
    logic [G_DATA_WIDTH-1:0] r_ram_q;

    // Buffer contents come up zero at configuration and survive rst_i.
    logic [G_DATA_WIDTH-1:0] r_mem [G_NUM_CHANNELS][DEPTH] = '{default: '0};

    logic                    w_req;
    logic                    w_is_data_rd;
    logic                    w_data_wr;
    logic                    w_mem_we;
    logic                    w_chan_ok;
    logic [CHW-1:0]          w_chan_idx;
    logic                    w_ptr_last;
    logic [G_DEPTH_LOG2-1:0] w_ptr_inc;
    logic [31:0]             w_ptr_rd;
    logic [31:0]             w_status;
    logic [31:0]             w_ram_ext;

    logic [1:0]              w_next_state;
    logic                    w_advance;
    logic                    w_ptr_wr;
    logic                    w_load_dat;
    logic [31:0]             w_dat_nxt;

    assign w_req        = wb_cyc_i & wb_stb_i;
    assign w_is_data_rd = w_req & ~wb_we_i & (wb_adr_i == A_DATA);
    assign w_data_wr    = (r_state == S_IDLE) & w_req & wb_we_i & (wb_adr_i == A_DATA);

    // Channels at or above G_NUM_CHANNELS have no storage: the RAM index is
    // forced to 0 for them and the data path masks the result.
    assign w_chan_ok  = ({1'b0, r_chan} < NUM_CH_5);
    assign w_chan_idx = w_chan_ok ? r_chan[CHW-1:0] : '0;
    assign w_mem_we   = w_data_wr & w_chan_ok & ~rst_i;

    assign w_ptr_last = &r_ptr;
    assign w_ptr_inc  = r_ptr + 1'b1;

    assign w_ptr_rd  = {12'h0, r_chan, 16'(r_ptr)};
    assign w_status  = {11'h0, 5'(G_DEPTH_LOG2), 8'(G_NUM_CHANNELS), 6'h0, r_err, r_wrapped};
    assign w_ram_ext = w_chan_ok ? 32'(r_ram_q) : 32'h0;

    // Synchronous-read RAM. The read port follows the live pointer every
    // cycle, so r_ram_q reflects {chan, ptr} one edge after they settle.
    always_ff @(posedge clk_sys_i) begin
        if (w_mem_we) begin
            r_mem[w_chan_idx][r_ptr] <= wb_dat_i[G_DATA_WIDTH-1:0];
        end
        r_ram_q <= r_mem[w_chan_idx][r_ptr];
    end

`ifdef WB_INDIRECT_BUFFER_PREFETCH_EN
    logic [1:0]              r_pf_cnt;
    logic                    r_pf_valid;
    logic [G_DATA_WIDTH-1:0] r_pf_data;
    logic [31:0]             w_pf_ext;

    // chan cannot change while r_pf_valid is set (a PTR write invalidates),
    // so the live channel check applies to the prefetched word as well.
    assign w_pf_ext = w_chan_ok ? 32'(r_pf_data) : 32'h0;

    // Refill: the edge that moves the pointer (or writes the RAM) arms the
    // counter, the next edge refreshes r_ram_q, the one after loads it here.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_pf_valid <= 1'b0;
            r_pf_cnt   <= 2'd2;
        end else if (w_ptr_wr | w_advance) begin
            r_pf_valid <= 1'b0;
            r_pf_cnt   <= 2'd2;
        end else if (r_pf_cnt == 2'd2) begin
            r_pf_cnt   <= 2'd1;
        end else if (r_pf_cnt == 2'd1) begin
            r_pf_data  <= r_ram_q;
            r_pf_valid <= 1'b1;
            r_pf_cnt   <= 2'd0;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        w_ptr_wr     = 1'b0;
        w_load_dat   = 1'b0;
        w_dat_nxt    = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_is_data_rd) begin
`ifdef WB_INDIRECT_BUFFER_PREFETCH_EN
                        if (r_pf_valid) begin
                            w_next_state = S_ACK;
                            w_advance    = 1'b1;
                            w_load_dat   = 1'b1;
                            w_dat_nxt    = w_pf_ext;
                        end else begin
                            w_next_state = S_RD_WAIT;
                        end
`else
                        w_next_state = S_RD_WAIT;
`endif
                    end else begin
                        w_next_state = S_ACK;
                        if (wb_we_i) begin
                            w_ptr_wr  = (wb_adr_i == A_PTR);
                            w_advance = (wb_adr_i == A_DATA);
                        end else begin
                            w_load_dat = 1'b1;
                            case (wb_adr_i)
                                A_PTR:    w_dat_nxt = w_ptr_rd;
                                A_STATUS: w_dat_nxt = w_status;
                                default:  w_dat_nxt = 32'h0;
                            endcase
                        end
                    end
                end
            end
            S_RD_WAIT: begin
                if (!wb_cyc_i) begin
                    w_next_state = S_IDLE;
                end else begin
`ifdef WB_INDIRECT_BUFFER_PREFETCH_EN
                    if (r_pf_valid) begin
                        w_next_state = S_ACK;
                        w_advance    = 1'b1;
                        w_load_dat   = 1'b1;
                        w_dat_nxt    = w_pf_ext;
                    end
`else
                    w_next_state = S_ACK;
                    w_advance    = 1'b1;
                    w_load_dat   = 1'b1;
                    w_dat_nxt    = w_ram_ext;
`endif
                end
            end
            S_ACK:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_chan    <= 4'h0;
            r_wrapped <= 1'b0;
            r_err     <= 1'b0;
            r_dat_o   <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (w_ptr_wr) begin
                r_ptr     <= wb_dat_i[G_DEPTH_LOG2-1:0];
                r_chan    <= wb_dat_i[19:16];
                r_wrapped <= 1'b0;
                r_err     <= 1'b0;
            end else if (w_advance) begin
                r_ptr <= w_ptr_inc;
                if (w_ptr_last) begin
                    r_wrapped <= 1'b1;
                end
                if (!w_chan_ok) begin
                    r_err <= 1'b1;
                end
            end
            if (w_load_dat) begin
                r_dat_o <= w_dat_nxt;
            end
        end
    end

    assign wb_ack_o = (r_state == S_ACK);
    assign wb_dat_o = r_dat_o;
    assign wrap_o   = r_wrapped;
    assign err_o    = r_err;

endmodule

// File: tb/tb_wb_indirect_buffer_port.sv
module tb_wb_indirect_buffer_port;

    localparam int DW    = 16;
    localparam int DL2   = 3;
    localparam int NC    = 2;
    localparam int DEPTH = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        wrap;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    wb_indirect_buffer_port #(
        .G_DATA_WIDTH  (DW),
        .G_DEPTH_LOG2  (DL2),
        .G_NUM_CHANNELS(NC)
    ) dut (
        .clk_sys_i(clk),
        .rst_i    (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_ack_o (ack),
        .wrap_o   (wrap),
        .err_o    (err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [NC][DEPTH];
    int            m_ptr;
    int            m_chan;
    bit            m_wrap;
    bit            m_err;
    logic [31:0]   m_dato;

    function automatic void model_reset();
        m_ptr  = 0;
        m_chan = 0;
        m_wrap = 0;
        m_err  = 0;
        m_dato = 32'h0;
    endfunction

    function automatic void model_access(input logic [1:0] a, input logic w, input logic [31:0] d);
        case (a)
            2'd0: begin
                if (w) begin
                    m_ptr  = int'(d) & (DEPTH - 1);
                    m_chan = int'((d >> 16) & 32'hF);
                    m_wrap = 0;
                    m_err  = 0;
                end else begin
                    m_dato = (m_chan * 65536) + m_ptr;
                end
            end
            2'd1: begin
                if (m_chan < NC) begin
                    if (w) m_mem[m_chan][m_ptr] = d[DW-1:0];
                    else   m_dato = 32'(m_mem[m_chan][m_ptr]);
                end else begin
                    if (!w) m_dato = 32'h0;
                    m_err = 1;
                end
                if (m_ptr == DEPTH - 1) m_wrap = 1;
                m_ptr = (m_ptr + 1) % DEPTH;
            end
            2'd2: if (!w) m_dato = (DL2 * 65536) + (NC * 256) + (int'(m_err) * 2) + int'(m_wrap);
            default: if (!w) m_dato = 32'h0;
        endcase
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_lat(input string name, input logic [1:0] a, input logic w, input int lat);
        bit ok;
        if (a == 2'd1 && !w) begin
`ifdef WB_INDIRECT_BUFFER_PREFETCH_EN
            ok = (lat >= 1 && lat <= 3);
`else
            ok = (lat == 2);
`endif
        end else begin
            ok = (lat == 1);
        end
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s_latency: got %0d cycles (0 = no ack) for adr=%0d we=%0d", name, lat, a, w);
    endtask

    // ---------------- driver ----------------
    task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        @(negedge clk);
        check("ack_idle_before_req", 32'(ack), 32'h0);
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat_i = d;
        lat = 0;
        rd  = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                rd  = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic op_model(input logic [1:0] a, input logic w, input logic [31:0] d, input string name);
        logic [31:0] rd;
        int          lat;
        wb_xfer(a, w, d, rd, lat);
        model_access(a, w, d);
        check_lat(name, a, w, lat);
        check({name, "_dat"}, rd, m_dato);
        check({name, "_wrap"}, 32'(wrap), 32'(m_wrap));
        check({name, "_err"}, 32'(err), 32'(m_err));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic        chk;
        logic [31:0] exp;
        logic        exp_wrap;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [1:0] a, input logic w, input logic [31:0] d,
                                input logic c, input logic [31:0] e, input logic ew, input logic ee);
        vec_t v;
        v.adr = a; v.we = w; v.dat = d; v.chk = c; v.exp = e; v.exp_wrap = ew; v.exp_err = ee;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [31:0] rd;
        int          lat;
        int          ack_cnt;
        logic [31:0] d;
        int          sel;
        int          ch;

        // 0=PTR 1=DATA 2=STATUS 3=reserved; STATUS default is 0x00030200
        // Basic write / read-back with auto-increment
        add(2, 0, 0, 1, 32'h00030200, 0, 0);
        add(0, 0, 0, 1, 32'h0, 0, 0);
        add(0, 1, 32'h0, 0, 0, 0, 0);
        add(1, 1, 32'h0, 0, 0, 0, 0);
        add(1, 1, 32'h1, 0, 0, 0, 0);
        add(0, 1, 32'h0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0, 0, 0);
        add(1, 0, 0, 1, 32'h1, 0, 0);
        add(1, 0, 0, 1, 32'h0, 0, 0);
        add(1, 0, 0, 1, 32'h0, 0, 0);
        add(1, 0, 0, 1, 32'h0, 0, 0);
        add(0, 0, 0, 1, 32'h5, 0, 0);
        add(2, 0, 0, 1, 32'h00030200, 0, 0);
        // Wrap at DEPTH-1 -> 0
        add(0, 1, 32'h7, 0, 0, 0, 0);
        add(1, 1, 32'hA5, 0, 0, 1, 0);
        add(1, 1, 32'h5A, 0, 0, 1, 0);
        add(0, 0, 0, 1, 32'h1, 1, 0);
        add(2, 0, 0, 1, 32'h00030201, 1, 0);
        add(0, 1, 32'h7, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'hA5, 1, 0);
        add(1, 0, 0, 1, 32'h5A, 1, 0);
        add(0, 1, 32'h0, 0, 0, 0, 0);
        add(2, 0, 0, 1, 32'h00030200, 0, 0);
        // Channel isolation and zero-extension of a 16-bit word
        add(0, 1, 32'h00010004, 0, 0, 0, 0);
        add(1, 1, 32'hDEADCAFE, 0, 0, 0, 0);
        add(0, 1, 32'h4, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0, 0, 0);
        add(0, 1, 32'h00010004, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0000CAFE, 0, 0);
        add(0, 0, 0, 1, 32'h00010005, 0, 0);
        // Nonexistent channel
        add(0, 1, 32'h000F0000, 0, 0, 0, 0);
        add(1, 1, 32'h1234, 0, 0, 0, 1);
        add(1, 0, 0, 1, 32'h0, 0, 1);
        add(0, 0, 0, 1, 32'h000F0002, 0, 1);
        add(2, 0, 0, 1, 32'h00030202, 0, 1);
        add(0, 1, 32'h0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h5A, 0, 0);
        add(1, 0, 0, 1, 32'h1, 0, 0);
        add(0, 1, 32'h00010000, 0, 0, 0, 0);
        add(1, 0, 0, 1, 32'h0, 0, 0);
        add(1, 0, 0, 1, 32'h0, 0, 0);
        // Reserved and read-only registers
        add(3, 0, 0, 1, 32'h0, 0, 0);
        add(3, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
        add(2, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
        add(2, 0, 0, 1, 32'h00030200, 0, 0);
        add(0, 0, 0, 1, 32'h00010002, 0, 0);

        for (int c = 0; c < NC; c++)
            for (int p = 0; p < DEPTH; p++)
                m_mem[c][p] = '0;
        model_reset();

        // ---------------- reset ----------------
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_i = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_dat_o", dat_o, 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            wb_xfer(tbl[i].adr, tbl[i].we, tbl[i].dat, rd, lat);
            model_access(tbl[i].adr, tbl[i].we, tbl[i].dat);
            check_lat($sformatf("vec%0d", i), tbl[i].adr, tbl[i].we, lat);
            if (tbl[i].chk) check($sformatf("vec%0d_rd", i), rd, tbl[i].exp);
            check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(tbl[i].exp_wrap));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
        end

        // ---------------- cyc dropped while a DATA read waits ----------------
        op_model(0, 1, 32'h00010006, "abort_setup");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 2'd1; we = 1'b0;
        @(negedge clk);
        ack_cnt = ack ? 1 : 0;
        cyc = 1'b0; stb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack) ack_cnt++;
        end
        check("abort_no_ack", 32'(ack_cnt), 32'h0);
        check("abort_dat_o_held", dat_o, m_dato);
        op_model(0, 0, 0, "abort_ptr_unchanged");

        // ---------------- reset aborting a DATA write ----------------
        op_model(0, 1, 32'h00010007, "rstwr_ptr");
        op_model(1, 1, 32'h1111, "rstwr_wrap");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 2'd1; we = 1'b1; dat_i = 32'h7777; rst = 1'b1;
        @(negedge clk);
        check("rstwr_no_ack", 32'(ack), 32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        model_reset();
        check("rstwr_wrap_cleared", 32'(wrap), 32'h0);
        op_model(0, 0, 0, "rstwr_ptr_zero");
        op_model(0, 1, 32'h00010000, "rstwr_ptr_set");
        op_model(1, 0, 0, "rstwr_ram_untouched");

        // ---------------- reset during ACK ----------------
        op_model(2, 0, 0, "rstack_status");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 2'd0; we = 1'b1; dat_i = 32'h00010003;
        @(negedge clk);
        check("rstack_ack_high", 32'(ack), 32'h1);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("rstack_ack_low", 32'(ack), 32'h0);
        check("rstack_dat_o", dat_o, 32'h0);
        rst = 1'b0;
        model_reset();
        op_model(0, 0, 0, "rstack_ptr");
        op_model(2, 0, 0, "rstack_status_default");

        // ---------------- read after idle, and no stale data ----------------
        op_model(0, 1, 32'h0, "pf_ptr");
        repeat (3) @(negedge clk);
        wb_xfer(2'd1, 1'b0, 32'h0, rd, lat);
        model_access(2'd1, 1'b0, 32'h0);
`ifdef WB_INDIRECT_BUFFER_PREFETCH_EN
        check("idle_read_latency", 32'(lat), 32'd1);
`else
        check("idle_read_latency", 32'(lat), 32'd2);
`endif
        check("idle_read_dat", rd, m_dato);
        op_model(0, 1, 32'h0, "stale_ptr");
        repeat (3) @(negedge clk);
        op_model(1, 1, 32'h4242, "stale_write");
        op_model(0, 1, 32'h0, "stale_ptr2");
        op_model(1, 0, 0, "stale_read");
        check("stale_read_value", m_dato, 32'h4242);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            d   = $urandom;
            if (sel <= 1) begin
                ch = ($urandom_range(0, 7) == 0) ? $urandom_range(NC, 15) : $urandom_range(0, NC - 1);
                d[19:16] = 4'(ch);
                op_model(2'd0, 1'b1, d, "rnd_ptr_wr");
            end else if (sel == 2) begin
                op_model(2'd0, 1'b0, d, "rnd_ptr_rd");
            end else if (sel <= 5) begin
                op_model(2'd1, 1'b1, d, "rnd_data_wr");
            end else if (sel <= 8) begin
                op_model(2'd1, 1'b0, d, "rnd_data_rd");
            end else begin
                op_model(2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), d, "rnd_misc");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
